// File: rtl/fft_pkg.sv
// Shared definitions for the FFT magnitude path: scan states and the
// default bin range / magnitude width also used by the FFT RAM writer.
package fft_pkg;

  localparam int FFT_MAG_W  = 16;
  localparam int FFT_BIN_LO = 1;
  localparam int FFT_BIN_HI = 119;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } fft_state_t;

endpackage

// File: rtl/peak_top2.sv
// Top-2 magnitude tracker. Keeps the largest and second-largest samples
// with their indices. The next-state values are exported so that a caller
// can capture the final result on the same edge as the last update.
// Comparisons are strict and unsigned, so on ties the earlier sample wins.
module peak_top2 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_256k,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] din_idx,
  output logic [DATA_W-1:0] max1_next,
  output logic [ADDR_W-1:0] idx1_next,
  output logic [ADDR_W-1:0] idx2_next
);

  logic [DATA_W-1:0] max1_reg, max2_reg, max2_next;
  logic [ADDR_W-1:0] idx1_reg, idx2_reg;

  // Clear has priority; otherwise fold the sample into the top-2 pair.
  always_comb begin
    max1_next = max1_reg;
    max2_next = max2_reg;
    idx1_next = idx1_reg;
    idx2_next = idx2_reg;
    if (clr) begin
      max1_next = '0;
      max2_next = '0;
      idx1_next = clr_idx;
      idx2_next = clr_idx;
    end else if (en) begin
      if (din > max1_reg) begin
        max2_next = max1_reg;
        idx2_next = idx1_reg;
        max1_next = din;
        idx1_next = din_idx;
      end else if (din > max2_reg) begin
        max2_next = din;
        idx2_next = din_idx;
      end
    end
  end

  // Tracker state register.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      max1_reg <= '0;
      max2_reg <= '0;
      idx1_reg <= '0;
      idx2_reg <= '0;
    end else begin
      max1_reg <= max1_next;
      max2_reg <= max2_next;
      idx1_reg <= idx1_next;
      idx2_reg <= idx2_next;
    end
  end

endmodule

// File: rtl/fft_peak_search.sv
// FFT peak finder. Each rising edge of wr_done scans bins BIN_LO..BIN_HI
// through the magnitude RAM read port, pairs returning data with its bin
// via a tag pipeline matching the RAM latency, and publishes the top-2
// bins, the peak magnitude and a below-threshold flag once per frame.
module fft_peak_search
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_MAG_W,
  parameter int ADDR_W = 8,
  parameter int BIN_LO = FFT_BIN_LO,
  parameter int BIN_HI = FFT_BIN_HI,
  parameter int RD_LAT = 1
) (
  input  logic              clk_256k,
  input  logic              rst_n,
  input  logic              wr_done,
  input  logic [DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              busy,
  output logic              freq_valid,
  output logic [ADDR_W-1:0] freq,
  output logic [ADDR_W-1:0] freq2,
  output logic [DATA_W-1:0] peak_mag,
  output logic              no_signal,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(BIN_HI);

  fft_state_t state_reg, state_next;

  logic              wr_done_d_reg;
  logic              armed_reg;
  logic              start;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [DATA_W-1:0] thresh_reg;
  logic              overrun_reg;
  logic [ADDR_W-1:0] freq_reg, freq2_reg;
  logic [DATA_W-1:0] peak_mag_reg;
  logic              no_signal_reg;

  logic              tag_vld_reg [RD_LAT];
  logic [ADDR_W-1:0] tag_idx_reg [RD_LAT];
  logic              last_ret;
  logic              trk_clr;
  logic              load_out;

  logic [DATA_W-1:0] max1_next;
  logic [ADDR_W-1:0] idx1_next, idx2_next;

  // A level that is already high when reset releases must go low once
  // before it can start a scan, hence the armed qualifier.
  assign start    = wr_done & ~wr_done_d_reg & armed_reg;
  assign last_ret = tag_vld_reg[RD_LAT-1] && (tag_idx_reg[RD_LAT-1] == ADDR_HI);

  assign rd_addr   = rd_addr_reg;
  assign freq      = freq_reg;
  assign freq2     = freq2_reg;
  assign peak_mag  = peak_mag_reg;
  assign no_signal = no_signal_reg;
  assign overrun   = overrun_reg;

  // State register.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    busy       = 1'b0;
    freq_valid = 1'b0;
    trk_clr    = 1'b0;
    load_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          trk_clr    = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (rd_addr_reg == ADDR_HI) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_ret) begin
          load_out   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        freq_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // wr_done edge detection and post-reset arming.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      wr_done_d_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      wr_done_d_reg <= wr_done;
      if (!wr_done) armed_reg <= 1'b1;
    end
  end

  // Read address counter; holds its last value while not scanning.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_reg <= ADDR_LO;
    end else if (state_reg == IDLE && start) begin
      rd_addr_reg <= ADDR_LO;
    end else if (state_reg == SCAN && rd_addr_reg != ADDR_HI) begin
      rd_addr_reg <= rd_addr_reg + 1'b1;
    end
  end

  // Tag pipeline: the last stage lines up with rd_data for the same read.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_vld_reg[s] <= 1'b0;
        tag_idx_reg[s] <= '0;
      end
    end else begin
      tag_vld_reg[0] <= rd_en;
      tag_idx_reg[0] <= rd_addr_reg;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_reg[s] <= tag_vld_reg[s-1];
        tag_idx_reg[s] <= tag_idx_reg[s-1];
      end
    end
  end

  // Threshold capture at scan start and sticky overrun flag.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      thresh_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) thresh_reg <= thresh;
      if (start && busy) overrun_reg <= 1'b1;
    end
  end

  // Result registers load from the tracker's next values on the edge that
  // consumes the last sample, so results appear together with freq_valid.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      freq_reg      <= '0;
      freq2_reg     <= '0;
      peak_mag_reg  <= '0;
      no_signal_reg <= 1'b0;
    end else if (load_out) begin
      freq_reg      <= idx1_next;
      freq2_reg     <= idx2_next;
      peak_mag_reg  <= max1_next;
      no_signal_reg <= (max1_next < thresh_reg);
    end
  end

  peak_top2 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_peak_top2 (
    .clk_256k  (clk_256k),
    .rst_n     (rst_n),
    .clr       (trk_clr),
    .clr_idx   (ADDR_LO),
    .en        (tag_vld_reg[RD_LAT-1]),
    .din       (rd_data),
    .din_idx   (tag_idx_reg[RD_LAT-1]),
    .max1_next (max1_next),
    .idx1_next (idx1_next),
    .idx2_next (idx2_next)
  );

endmodule

// File: tb/tb_fft_peak_search.sv
// Bench for fft_peak_search: four instances with RD_LAT 1..4 share one
// magnitude RAM image; each has its own RAM read pipeline of matching latency.
module tb_fft_peak_search;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NI = 4;
  localparam int N  = FFT_BIN_HI - FFT_BIN_LO + 1;

  logic clk_256k = 1'b0;
  always #5 clk_256k = ~clk_256k;

  logic          rst_n;
  logic          wr_done;
  logic [DW-1:0] thresh;
  logic [DW-1:0] ram [256];

  logic [AW-1:0] rd_addr_a [NI];
  logic [AW-1:0] freq_a    [NI];
  logic [AW-1:0] freq2_a   [NI];
  logic [DW-1:0] rd_data_a [NI];
  logic [DW-1:0] peak_a    [NI];
  logic          rd_en_a   [NI];
  logic          busy_a    [NI];
  logic          fv_a      [NI];
  logic          ns_a      [NI];
  logic          ovr_a     [NI];

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_pulses = 0;
  int   pulse_cnt [NI] = '{default: 0};
  logic addr0_seen = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int LAT = gi + 1;
      logic [DW-1:0] pipe [LAT];

      always @(posedge clk_256k) begin
        pipe[0] <= ram[rd_addr_a[gi]];
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
      end
      assign rd_data_a[gi] = pipe[LAT-1];

      fft_peak_search #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .BIN_LO (FFT_BIN_LO),
        .BIN_HI (FFT_BIN_HI),
        .RD_LAT (LAT)
      ) u_dut (
        .clk_256k   (clk_256k),
        .rst_n      (rst_n),
        .wr_done    (wr_done),
        .thresh     (thresh),
        .rd_data    (rd_data_a[gi]),
        .rd_addr    (rd_addr_a[gi]),
        .rd_en      (rd_en_a[gi]),
        .busy       (busy_a[gi]),
        .freq_valid (fv_a[gi]),
        .freq       (freq_a[gi]),
        .freq2      (freq2_a[gi]),
        .peak_mag   (peak_a[gi]),
        .no_signal  (ns_a[gi]),
        .overrun    (ovr_a[gi])
      );
    end
  endgenerate

  // Count freq_valid pulses per instance.
  always @(posedge clk_256k) begin
    for (int i = 0; i < NI; i++)
      if (fv_a[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
  end

  // Bin 0 must never be addressed.
  always @(negedge clk_256k) begin
    for (int i = 0; i < NI; i++)
      if (rd_addr_a[i] == 8'd0) addr0_seen <= 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_ram(input logic [DW-1:0] v);
    for (int a = 0; a < 256; a++) ram[a] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_freq"},    int'(freq_a[0]), 0);
    chk({tag, "_freq2"},   int'(freq2_a[0]), 0);
    chk({tag, "_peak"},    int'(peak_a[0]), 0);
    chk({tag, "_nosig"},   int'(ns_a[0]), 0);
    chk({tag, "_ovr"},     int'(ovr_a[0]), 0);
    chk({tag, "_fvalid"},  int'(fv_a[0]), 0);
    chk({tag, "_busy"},    int'(busy_a[0]), 0);
    chk({tag, "_rden"},    int'(rd_en_a[0]), 0);
    for (int i = 0; i < NI; i++)
      chk($sformatf("%s_rdaddr_L%0d", tag, i + 1), int'(rd_addr_a[i]), FFT_BIN_LO);
  endtask

  // One frame: drop wr_done, raise it (start seen on the next edge = cycle 0),
  // optionally toggle wr_done mid-frame or assert reset, then check results.
  task automatic run_frame(input string name, input logic [DW-1:0] th,
                           input int tog_cyc, input int rst_cyc,
                           input int e_freq, input int e_freq2,
                           input int e_peak, input int e_ns);
    int lat [NI];
    for (int i = 0; i < NI; i++) lat[i] = -1;
    @(negedge clk_256k);
    wr_done = 1'b0;
    thresh  = th;
    repeat (2) @(negedge clk_256k);
    wr_done = 1'b1;
    for (int cyc = 1; cyc <= N + 20; cyc++) begin
      @(posedge clk_256k);
      #1;
      if (cyc == 1) begin
        chk({name, "_c1_rdaddr"}, int'(rd_addr_a[0]), FFT_BIN_LO);
        chk({name, "_c1_rden"},   int'(rd_en_a[0]), 1);
        chk({name, "_c1_busy"},   int'(busy_a[0]), 1);
      end
      if (cyc == N) begin
        chk({name, "_cN_rdaddr"}, int'(rd_addr_a[0]), FFT_BIN_HI);
        chk({name, "_cN_rden"},   int'(rd_en_a[0]), 1);
      end
      if (cyc == N + 1) chk({name, "_cN1_rden"}, int'(rd_en_a[0]), 0);
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs(name);
        $display("frame %s: reset asserted at cycle %0d", name, cyc);
        return;
      end
      if (tog_cyc != 0 && cyc == tog_cyc)     wr_done = 1'b0;
      if (tog_cyc != 0 && cyc == tog_cyc + 1) wr_done = 1'b1;
      for (int i = 0; i < NI; i++)
        if (fv_a[i] && lat[i] < 0) lat[i] = cyc;
    end
    exp_pulses++;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_lat_L%0d", name, i + 1),   lat[i], N + i + 2);
      chk($sformatf("%s_freq_L%0d", name, i + 1),  int'(freq_a[i]), e_freq);
      chk($sformatf("%s_freq2_L%0d", name, i + 1), int'(freq2_a[i]), e_freq2);
      chk($sformatf("%s_peak_L%0d", name, i + 1),  int'(peak_a[i]), e_peak);
      chk($sformatf("%s_nosig_L%0d", name, i + 1), int'(ns_a[i]), e_ns);
      chk($sformatf("%s_pulses_L%0d", name, i + 1), pulse_cnt[i], exp_pulses);
    end
    $display("frame %s: freq=%0d freq2=%0d peak=%0d no_signal=%0d latency=%0d/%0d/%0d/%0d",
             name, freq_a[0], freq2_a[0], peak_a[0], ns_a[0], lat[0], lat[1], lat[2], lat[3]);
  endtask

  initial begin
    int busy_seen;
    rst_n   = 1'b0;
    wr_done = 1'b0;
    thresh  = '0;
    fill_ram('0);
    repeat (3) @(negedge clk_256k);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_256k);
    check_reset_outputs("post_rst");

    // Single peak, all latencies.
    fill_ram('0);
    ram[40] = 16'd1000;
    ram[80] = 16'd500;
    run_frame("single", 16'd100, 0, 0, 40, 80, 1000, 0);

    // Equal maxima: lower bin wins, higher equal bin becomes second.
    fill_ram('0);
    ram[10] = 16'd700;
    ram[90] = 16'd700;
    ram[50] = 16'd300;
    run_frame("tie", 16'd100, 0, 0, 10, 90, 700, 0);

    // Flat spectrum below threshold; out-of-range bins hold large values.
    fill_ram(16'd60000);
    for (int a = FFT_BIN_LO; a <= FFT_BIN_HI; a++) ram[a] = 16'd20;
    ram[0] = 16'd9999;
    run_frame("thresh", 16'd50, 0, 0, 1, 2, 20, 1);
    chk("thresh_ovr", int'(ovr_a[0]), 0);

    // Re-arm: two frames, stray wr_done toggle during the second.
    fill_ram('0);
    ram[30] = 16'd800;
    run_frame("frame_a", 16'd100, 0, 0, 30, 1, 800, 0);
    chk("frame_a_ovr", int'(ovr_a[0]), 0);
    ram[60] = 16'd900;
    run_frame("frame_b", 16'd100, 50, 0, 60, 30, 900, 0);
    for (int i = 0; i < NI; i++)
      chk($sformatf("frame_b_ovr_L%0d", i + 1), int'(ovr_a[i]), 1);
    repeat (20) @(negedge clk_256k);
    chk("frame_b_idle_busy", int'(busy_a[0]), 0);
    chk("frame_b_no_extra", pulse_cnt[0], exp_pulses);

    // Reset mid-scan, then held-high wr_done must not rescan.
    fill_ram('0);
    ram[40] = 16'd1000;
    ram[80] = 16'd500;
    run_frame("reset_mid", 16'd100, 0, 60, 0, 0, 0, 0);
    repeat (2) @(negedge clk_256k);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_256k);
      for (int i = 0; i < NI; i++) if (busy_a[i] || rd_en_a[i]) busy_seen = 1;
    end
    chk("held_wr_done_no_scan", busy_seen, 0);
    $display("frame held_high: busy_seen=%0d", busy_seen);
    run_frame("after_reset", 16'd100, 0, 0, 40, 80, 1000, 0);

    chk("never_read_bin0", int'(addr0_seen), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_search.md
# fft_peak_search

Parametrised FFT peak finder between the FFT magnitude RAM and the frequency/measurement logic. On every rising edge of `wr_done` it scans a programmable bin range through the RAM read port and tracks the largest and second-largest magnitudes with their bin indices. It compensates a configurable RAM read latency, reports a below-threshold ("no signal") condition, and re-arms itself for every frame.

## Interface
- `DATA_W`, 16, magnitude width
- `ADDR_W`, 8, RAM address / bin index width
- `BIN_LO`, 1, first bin scanned (bin 0/DC excluded by default)
- `BIN_HI`, 119, last bin scanned; must satisfy BIN_LO ≤ BIN_HI ≤ 2^ADDR_W−1
- `RD_LAT`, 1, RAM read latency in cycles, 1..4
- `clk_256k` in 1: system clock; all logic on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `wr_done` in 1: frame-written level from the FFT RAM writer; its rising edge starts a scan
- `thresh` in DATA_W: no-signal threshold; sampled at scan start
- `rd_data` in DATA_W: RAM read data, valid RD_LAT cycles after `rd_addr`
- `rd_addr` out ADDR_W: RAM read address
- `rd_en` out 1: high on cycles issuing a valid read
- `busy` out 1: high from scan start until the cycle of `freq_valid`
- `freq_valid` out 1: one-cycle pulse when results update
- `freq` out ADDR_W: bin index of the largest magnitude
- `freq2` out ADDR_W: bin index of the second-largest magnitude
- `peak_mag` out DATA_W: largest magnitude
- `no_signal` out 1: peak_mag < sampled thresh
- `overrun` out 1: sticky; set when a `wr_done` rising edge arrives while busy

## Operation
- Reset values: all outputs 0; `rd_addr` = BIN_LO; state IDLE; `wr_done` edge register = 0.
- Edge detect: `start = wr_done & ~wr_done_d`. While `wr_done` stays high, no rescan occurs.
- States:
  - IDLE: on `start`, clear max1/max2 to 0 and idx1/idx2 to BIN_LO, latch `thresh`, and go to SCAN.
  - SCAN: `rd_en`=1; `rd_addr` steps BIN_LO..BIN_HI, one address per cycle. After issuing BIN_HI, go to DRAIN.
  - DRAIN: wait until the last tagged read returns, then go to DONE.
  - DONE: register outputs, pulse `freq_valid`, return to IDLE.
- A valid/index shift register of depth RD_LAT pairs each returning `rd_data` with its address. Untagged data is ignored.
- Update rule for each tagged sample (d, i):
  - if d > max1: max2←max1, idx2←idx1, max1←d, idx1←i
  - else if d > max2: max2←d, idx2←i
- Comparisons are strict and unsigned, so on ties the lower bin wins.
- When N=1, `freq2` = BIN_LO and max2 = 0.
- Outputs `freq`, `freq2`, `peak_mag` and `no_signal` hold their values between frames.
- `start` while busy is ignored and sets `overrun`. `overrun` clears only on reset.
- Reset asserted mid-scan aborts immediately to reset values. There is no partial-result output.

## Timing
- Let N = BIN_HI−BIN_LO+1 and let cycle 0 be the edge where `start` is seen.
- Cycles 1..N: `rd_en`=1, `rd_addr`=BIN_LO+k−1 on cycle k.
- The data for the last address arrives in cycle N+RD_LAT.
- `freq_valid` = 1 and the new outputs are visible in cycle N+RD_LAT+1. `busy` drops in the same cycle.
- The earliest accepted next `start` is cycle N+RD_LAT+2.
- `rd_addr` holds its last value while idle. The RAM must tolerate reads with `rd_en`=0.

## Structure
- A shared package `fft_pkg` holds:
  - the state enum {IDLE, SCAN, DRAIN, DONE}
  - default constants FFT_BIN_LO, FFT_BIN_HI and FFT_MAG_W, also used by the FFT writer.
- Sub-module `peak_top2`: a combinational-plus-register top-2 tracker with clear/enable ports and parameter DATA_W/ADDR_W. It is reusable for harmonic measurement.
- The FSM, address counter and latency pipeline live in the top module.

## Test plan
- Single peak:
  - RAM all 0 except bin 40 = 1000 and bin 80 = 500, thresh = 100, RD_LAT = 1.
  - Required: `freq`=40, `freq2`=80, `peak_mag`=1000, `no_signal`=0.
  - `freq_valid` pulses exactly 121 cycles after `start`.
- Tie and order:
  - bins 10 and 90 = 700, bin 50 = 300.
  - Required: `freq`=10, `freq2`=90.
- Latency sweep:
  - Repeat the single-peak case with RD_LAT = 2, 3 and 4.
  - Required: identical results; `freq_valid` at cycles 122, 123 and 124 respectively.
- Threshold:
  - all bins 20, thresh = 50.
  - Required: `no_signal`=1, `peak_mag`=20, `freq`=BIN_LO=1.
  - Bin 0 = 9999 is never read (`rd_addr` never 0).
- Re-arm and overrun:
  - Two frames with peaks at 30, then 60.
  - Required: two `freq_valid` pulses with `freq` 30 then 60.
  - A `wr_done` toggle at cycle 50 of frame 2 sets `overrun`=1 and does not disturb the frame 2 result.
- Reset mid-scan:
  - Assert `rst_n`=0 at cycle 60.
  - Required: all outputs 0 and `rd_addr`=1 immediately.
  - Held-high `wr_done` after reset release does not start a scan until it toggles low then high.
